// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the TX drain and the planned RX block.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LATCH,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last count of each bit.
module baud_tick #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_drain.sv
// Pops bytes from the registered-output FIFO and serialises them as 8N1 UART.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
//
// state  | meaning
// IDLE   | line high, waiting for tx_en and a non-empty FIFO
// POP    | one-cycle fifo_deq pulse
// LATCH  | FIFO output now valid, captured into the shift register
// START  | start bit (low)
// DATA   | WIDTH data bits, LSB first
// PARITY | even-parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high), frame_done in its last cycle
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLK_FREQ_HZ  = 100000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             fifo_deq,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_drain: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t        state;
  tx_state_t        state_next;
  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] bit_idx;
  logic             tick;
  logic             clr;
  logic             last_bit;
`ifdef UART_TX_PARITY_EN
  logic             parity_bit;
`endif

  // Counter restarts on every state change so each bit gets a full period.
  assign clr      = (state_next != state) || (state == IDLE);
  assign last_bit = (bit_idx == LAST_BIT);

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (tx_en && !fifo_empty) state_next = POP;
      POP:   state_next = LATCH;
      LATCH: state_next = START;
      START: if (tick) state_next = DATA;
      DATA: begin
        if (tick && last_bit) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (tick) state_next = STOP;
`endif
      STOP:  if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        LATCH: begin
          shreg   <= fifo_dout;
          bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
          parity_bit <= ^fifo_dout;
`endif
        end
        DATA: begin
          if (tick) begin
            shreg   <= shreg >> 1;
            bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx = UART_IDLE_LEVEL;
    case (state)
      START: tx = ~UART_IDLE_LEVEL;
      DATA:  tx = shreg[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx = parity_bit;
`endif
      default: tx = UART_IDLE_LEVEL;
    endcase
  end

  assign fifo_deq   = (state == POP);
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && tick;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with a behavioural registered-output FIFO.
module tb_uart_tx_drain;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FLEN = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_deq;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [7:0] fifo_q[$];
  int vectors = 0;
  int miscompares = 0;
  int deq_cnt = 0;
  int deq_empty = 0;
  logic last_parity;

  uart_tx_drain #(
    .WIDTH      (8),
    .CLK_FREQ_HZ(40),
    .BAUD       (10)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_deq  (fifo_deq),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_deq) begin
      deq_cnt++;
      if (fifo_q.size() == 0) deq_empty++;
      else fifo_dout <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    @(posedge clk);
    #1;
    fifo_q.push_back(b);
  endtask

  function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^b;
`endif
    return f;
  endfunction

  task automatic wait_start(output int gap, output bit ok);
    gap = 0;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        ok = 1;
        break;
      end
      gap++;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL start_timeout: got no start bit, want start within 200 cycles");
    end
  endtask

  // Entered at the first START-cycle negedge; leaves at the last STOP-cycle negedge.
  task automatic check_frame(input logic [7:0] b);
    logic [NBITS-1:0] exp_bits;
    logic [CPB-1:0]   obs[NBITS];
    int done_cnt;
    int done_pos;
    int busy_bad;
    exp_bits = frame_bits(b);
    done_cnt = 0;
    done_pos = -1;
    busy_bad = 0;
    for (int c = 0; c < FLEN; c++) begin
      obs[c / CPB][c % CPB] = tx;
      if (frame_done === 1'b1) begin
        done_cnt++;
        done_pos = c;
      end
      if (busy !== 1'b1) busy_bad++;
      if (c < FLEN - 1) @(negedge clk);
    end
    last_parity = obs[NBITS-2][0];
    for (int j = 0; j < NBITS; j++) begin
      vectors++;
      if (obs[j] !== {CPB{exp_bits[j]}}) begin
        miscompares++;
        $display("FAIL frame_%h bit%0d: got %b want %b", b, j, obs[j], {CPB{exp_bits[j]}});
      end
    end
    vectors++;
    if (done_cnt !== 1 || done_pos !== FLEN - 1) begin
      miscompares++;
      $display("FAIL frame_done_%h: got %0d pulses at cycle %0d, want 1 at cycle %0d",
               b, done_cnt, done_pos, FLEN - 1);
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL busy_in_frame_%h: got %0d low cycles, want 0", b, busy_bad);
    end
  endtask

  task automatic check_idle(input string name);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_deq !== 1'b0 || frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got tx=%b busy=%b deq=%b done=%b, want 1 0 0 0",
               name, tx, busy, fifo_deq, frame_done);
    end
  endtask

  task automatic test_reset();
    int moved;
    int d0;
    reset = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_held");
    reset = 1'b1;
    @(negedge clk);
    check_idle("reset_released");
    tx_en = 1'b1;
    d0 = deq_cnt;
    moved = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) moved++;
    end
    vectors++;
    if (moved !== 0 || deq_cnt - d0 !== 0) begin
      miscompares++;
      $display("FAIL empty_idle: got %0d active cycles %0d pops, want 0 0", moved, deq_cnt - d0);
    end
  endtask

  task automatic test_single_byte();
    int gap;
    bit ok;
    int d0;
    tx_en = 1'b1;
    d0 = deq_cnt;
    push(8'hA5);
    wait_start(gap, ok);
    if (ok) check_frame(8'hA5);
    repeat (10) @(negedge clk);
    vectors++;
    if (deq_cnt - d0 !== 1) begin
      miscompares++;
      $display("FAIL single_deq: got %0d pops, want 1", deq_cnt - d0);
    end
    vectors++;
    if (fifo_q.size() !== 0) begin
      miscompares++;
      $display("FAIL single_fifo_empty: got %0d entries, want 0", fifo_q.size());
    end
    check_idle("single_after");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    int gap;
    bit ok;
    int d0;
    bytes[0] = 8'h11;
    bytes[1] = 8'h22;
    bytes[2] = 8'h33;
    tx_en = 1'b1;
    d0 = deq_cnt;
    push(bytes[0]);
    push(bytes[1]);
    push(bytes[2]);
    for (int k = 0; k < 3; k++) begin
      wait_start(gap, ok);
      if (!ok) break;
      if (k > 0) begin
        vectors++;
        if (gap !== 3) begin
          miscompares++;
          $display("FAIL b2b_gap%0d: got %0d high cycles, want 3", k, gap);
        end
      end
      check_frame(bytes[k]);
    end
    repeat (30) @(negedge clk);
    vectors++;
    if (deq_cnt - d0 !== 3 || deq_empty !== 0) begin
      miscompares++;
      $display("FAIL b2b_deq: got %0d pops %0d on empty, want 3 0", deq_cnt - d0, deq_empty);
    end
    check_idle("b2b_after");
  endtask

  task automatic test_pacing();
    int gap;
    bit ok;
    int d0;
    int low;
    tx_en = 1'b0;
    d0 = deq_cnt;
    push(8'h44);
    push(8'h55);
    low = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low++;
    end
    vectors++;
    if (deq_cnt - d0 !== 0 || low !== 0) begin
      miscompares++;
      $display("FAIL pacing_hold: got %0d pops %0d active cycles, want 0 0", deq_cnt - d0, low);
    end
    tx_en = 1'b1;
    wait_start(gap, ok);
    tx_en = 1'b0;
    if (ok) check_frame(8'h44);
    repeat (30) @(negedge clk);
    vectors++;
    if (deq_cnt - d0 !== 1 || fifo_q.size() !== 1) begin
      miscompares++;
      $display("FAIL pacing_stop: got %0d pops %0d left, want 1 1", deq_cnt - d0, fifo_q.size());
    end
    check_idle("pacing_after");
    tx_en = 1'b1;
    wait_start(gap, ok);
    if (ok) check_frame(8'h55);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int gap;
    bit ok;
    int d0;
    tx_en = 1'b1;
    d0 = deq_cnt;
    push(8'hFF);
    push(8'h01);
    wait_start(gap, ok);
    // Cycles 16..19 of the frame carry data bit 3.
    repeat (17) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got tx=%b busy=%b, want 1 0", tx, busy);
    end
    reset = 1'b1;
    wait_start(gap, ok);
    if (ok) check_frame(8'h01);
    repeat (30) @(negedge clk);
    vectors++;
    if (deq_cnt - d0 !== 2 || fifo_q.size() !== 0 || deq_empty !== 0) begin
      miscompares++;
      $display("FAIL mid_reset_deq: got %0d pops %0d left %0d on empty, want 2 0 0",
               deq_cnt - d0, fifo_q.size(), deq_empty);
    end
    check_idle("mid_reset_after");
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    int gap;
    bit ok;
    tx_en = 1'b1;
    push(8'h07);
    wait_start(gap, ok);
    if (ok) begin
      check_frame(8'h07);
      vectors++;
      if (last_parity !== 1'b1) begin
        miscompares++;
        $display("FAIL parity_07: got %b want 1", last_parity);
      end
    end
    push(8'h03);
    wait_start(gap, ok);
    if (ok) begin
      check_frame(8'h03);
      vectors++;
      if (last_parity !== 1'b0) begin
        miscompares++;
        $display("FAIL parity_03: got %b want 0", last_parity);
      end
    end
    repeat (10) @(negedge clk);
    check_idle("parity_after");
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_pacing();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
